// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared encodings and defaults for the up/down counter family
package updown_pkg;

   localparam logic [1:0] MODE_UPWRAP  = 2'b00;
   localparam logic [1:0] MODE_DNWRAP  = 2'b01;
   localparam logic [1:0] MODE_BOUNCE  = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   localparam logic [1:0] DEF_MODE = MODE_BOUNCE;
   // Default window spans the whole range at any width: lo all-zeros, hi all-ones.
   localparam logic DEF_LO_BIT = 1'b0;
   localparam logic DEF_HI_BIT = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_HOLD,
      ST_DONE
   } state_t;

   function automatic logic mode_legal(input logic [1:0] mode);
      return mode != MODE_ILLEGAL;
   endfunction

endpackage

// File: rtl/updown_seq_ctrl_if.sv
// rtl/updown_seq_ctrl_if.sv - valid/ready configuration port of the counter sequencer
interface updown_seq_ctrl_if #(
   parameter int WIDTH = 3,
   parameter int SWW   = 8
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_lo;
   logic [WIDTH-1:0] cfg_hi;
   logic [1:0]       cfg_mode;
   logic [SWW-1:0]   cfg_sweeps;

   modport master (
      output cfg_valid, cfg_lo, cfg_hi, cfg_mode, cfg_sweeps,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_lo, cfg_hi, cfg_mode, cfg_sweeps,
      output cfg_ready
   );

endinterface

// File: rtl/updown_next.sv
// rtl/updown_next.sv - one-step next-value logic for a windowed up/down counter
module updown_next
   import updown_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             dir,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] next_cnt,
   output logic             next_dir,
   output logic             sweep_evt
);

   always_comb begin
      next_cnt  = cnt;
      next_dir  = dir;
      sweep_evt = 1'b0;
      case (mode)
         MODE_UPWRAP: begin
            if (cnt == hi) begin
               next_cnt  = lo;
               sweep_evt = 1'b1;
            end else begin
               next_cnt = cnt + WIDTH'(1);
            end
         end
         MODE_DNWRAP: begin
            if (cnt == lo) begin
               next_cnt  = hi;
               sweep_evt = 1'b1;
            end else begin
               next_cnt = cnt - WIDTH'(1);
            end
         end
         MODE_BOUNCE: begin
            // Turnaround steps straight to the neighbour so the endpoint is not repeated.
            if (!dir && cnt == hi) begin
               next_cnt  = hi - WIDTH'(1);
               next_dir  = 1'b1;
               sweep_evt = 1'b1;
            end else if (dir && cnt == lo) begin
               next_cnt  = lo + WIDTH'(1);
               next_dir  = 1'b0;
               sweep_evt = 1'b1;
            end else if (!dir) begin
               next_cnt = cnt + WIDTH'(1);
            end else begin
               next_cnt = cnt - WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/updown_seq_ctrl.sv
// rtl/updown_seq_ctrl.sv - config/run sequencer for the windowed up/down counter
module updown_seq_ctrl
   import updown_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int SWW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   updown_seq_ctrl_if.slave cfg,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] cnt,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic [1:0]       mode_q;
   logic [SWW-1:0]   sweeps_q, sweep_cnt;
   logic [WIDTH-1:0] next_cnt;
   logic             next_dir, sweep_evt;
   logic             cfg_fire, cfg_ok, finish, step_en;

   updown_next #(.WIDTH(WIDTH)) u_next (
      .cnt      (cnt),
      .dir      (dir),
      .lo       (lo_q),
      .hi       (hi_q),
      .mode     (mode_q),
      .next_cnt (next_cnt),
      .next_dir (next_dir),
      .sweep_evt(sweep_evt)
   );

   assign cfg_fire = cfg.cfg_valid && (state == ST_IDLE);
   assign cfg_ok   = (cfg.cfg_lo < cfg.cfg_hi) && mode_legal(cfg.cfg_mode);
   assign finish   = sweep_evt && (sweeps_q != '0) && (sweep_cnt + SWW'(1) == sweeps_q);
   assign step_en  = (state == ST_RUN) && !stop && !pause && !finish;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_RUN;
         ST_RUN: begin
            if (stop)        state_nxt = ST_IDLE;
            else if (pause)  state_nxt = ST_HOLD;
            else if (finish) state_nxt = ST_DONE;
         end
         ST_HOLD: begin
            if (stop)        state_nxt = ST_IDLE;
            else if (!pause) state_nxt = ST_RUN;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg.cfg_ready = (state == ST_IDLE);
      busy          = (state != ST_IDLE);
      done          = (state == ST_DONE);
   end

   // A rejected offer leaves the stored config untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q     <= {WIDTH{DEF_LO_BIT}};
         hi_q     <= {WIDTH{DEF_HI_BIT}};
         mode_q   <= DEF_MODE;
         sweeps_q <= '0;
         err      <= 1'b0;
      end else begin
         err <= cfg_fire && !cfg_ok;
         if (cfg_fire && cfg_ok) begin
            lo_q     <= cfg.cfg_lo;
            hi_q     <= cfg.cfg_hi;
            mode_q   <= cfg.cfg_mode;
            sweeps_q <= cfg.cfg_sweeps;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         dir       <= 1'b0;
         sweep_cnt <= '0;
      end else if (state == ST_LOAD) begin
         cnt       <= (mode_q == MODE_DNWRAP) ? hi_q : lo_q;
         dir       <= (mode_q == MODE_DNWRAP);
         sweep_cnt <= '0;
      end else if (step_en) begin
         cnt <= next_cnt;
         dir <= next_dir;
         if (sweep_evt && sweep_cnt != '1) sweep_cnt <= sweep_cnt + SWW'(1);
      end
   end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb/tb_updown_seq_ctrl.sv - directed self-checking bench for updown_seq_ctrl
module tb_updown_seq_ctrl;

   localparam int WIDTH = 3;
   localparam int SWW   = 8;

   logic             clk = 1'b0;
   logic             rst, start, pause, stop;
   logic [WIDTH-1:0] cnt;
   logic             dir, busy, done, err;
   logic [5:0]       obs;
   logic [5:0]       exp_v;
   int               tests_run    = 0;
   int               tests_failed = 0;

   updown_seq_ctrl_if #(.WIDTH(WIDTH), .SWW(SWW)) cfg_if ();

   updown_seq_ctrl #(.WIDTH(WIDTH), .SWW(SWW)) dut (
      .clk  (clk),
      .rst  (rst),
      .cfg  (cfg_if),
      .start(start),
      .pause(pause),
      .stop (stop),
      .cnt  (cnt),
      .dir  (dir),
      .busy (busy),
      .done (done),
      .err  (err)
   );

   always #5 clk = ~clk;

   assign obs = {cnt, dir, busy, done};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int lo, input int hi, input int mode, input int sweeps, input logic go);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_lo     = WIDTH'(lo);
      cfg_if.cfg_hi     = WIDTH'(hi);
      cfg_if.cfg_mode   = 2'(mode);
      cfg_if.cfg_sweeps = SWW'(sweeps);
      start             = go;
      tick();
      cfg_if.cfg_valid  = 1'b0;
      start             = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_lo = '0; cfg_if.cfg_hi = '0;
      cfg_if.cfg_mode = 2'b00; cfg_if.cfg_sweeps = '0;
      tick(); tick();
      rst = 1'b0;
      tests_run++;
      if ({obs, err} !== 7'b0000000) begin
         tests_failed++; $display("FAIL reset_outputs: got %b expected %b", {obs, err}, 7'b0000000);
      end
      tests_run++;
      if (cfg_if.cfg_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_if.cfg_ready);
      end
   endtask

   task automatic test_default_bounce();
      int seq [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
      start = 1'b1; tick(); start = 1'b0;
      tests_run++;
      if ({cnt, busy} !== {3'd0, 1'b1}) begin
         tests_failed++; $display("FAIL dflt_load: got %b expected %b", {cnt, busy}, {3'd0, 1'b1});
      end
      tick();
      tests_run++;
      if (obs !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL dflt_first: got %b expected %b", obs, {3'd0, 3'b010});
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         exp_v = {WIDTH'(seq[i]), (i >= 7 && i <= 13) ? 1'b1 : 1'b0, 1'b1, 1'b0};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++; $display("FAIL dflt_seq[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
      stop = 1'b1; tick(); stop = 1'b0;
      tests_run++;
      if ({obs, cfg_if.cfg_ready} !== {3'd2, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         tests_failed++; $display("FAIL dflt_stop: got %b expected %b", {obs, cfg_if.cfg_ready}, 7'b0100001);
      end
   endtask

   task automatic test_upwrap_sweeps();
      int seq [7] = '{3, 4, 5, 2, 3, 4, 5};
      offer(2, 5, 0, 2, 1'b1);
      tests_run++;
      if ({err, busy} !== 2'b01) begin
         tests_failed++; $display("FAIL up_accept: got %b expected 01", {err, busy});
      end
      tick();
      tests_run++;
      if (obs !== {3'd2, 3'b010}) begin
         tests_failed++; $display("FAIL up_load: got %b expected %b", obs, {3'd2, 3'b010});
      end
      for (int i = 0; i < 7; i++) begin
         tick();
         exp_v = {WIDTH'(seq[i]), 3'b010};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++; $display("FAIL up_seq[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
      tick();
      tests_run++;
      if (obs !== {3'd5, 3'b011}) begin
         tests_failed++; $display("FAIL up_done: got %b expected %b", obs, {3'd5, 3'b011});
      end
      tick();
      tests_run++;
      if (obs !== {3'd5, 3'b000}) begin
         tests_failed++; $display("FAIL up_after_done: got %b expected %b", obs, {3'd5, 3'b000});
      end
   endtask

   task automatic test_bounce_sweeps();
      int seq [3] = '{2, 1, 2};
      logic dseq [3] = '{1'b0, 1'b1, 1'b0};
      offer(1, 2, 2, 3, 1'b0);
      tests_run++;
      if ({err, busy} !== 2'b00) begin
         tests_failed++; $display("FAIL bnc_accept: got %b expected 00", {err, busy});
      end
      start = 1'b1; tick(); start = 1'b0;
      tick();
      tests_run++;
      if (obs !== {3'd1, 3'b010}) begin
         tests_failed++; $display("FAIL bnc_load: got %b expected %b", obs, {3'd1, 3'b010});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = {WIDTH'(seq[i]), dseq[i], 1'b1, 1'b0};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++; $display("FAIL bnc_seq[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
      tick();
      tests_run++;
      if (obs !== {3'd2, 3'b011}) begin
         tests_failed++; $display("FAIL bnc_done: got %b expected %b", obs, {3'd2, 3'b011});
      end
      tick();
      tests_run++;
      if (obs !== {3'd2, 3'b000}) begin
         tests_failed++; $display("FAIL bnc_after_done: got %b expected %b", obs, {3'd2, 3'b000});
      end
   endtask

   task automatic test_pause_stop();
      int seq [5] = '{5, 4, 4, 4, 4};
      offer(3, 6, 1, 0, 1'b1);
      tick();
      tests_run++;
      if (obs !== {3'd6, 3'b110}) begin
         tests_failed++; $display("FAIL dn_load: got %b expected %b", obs, {3'd6, 3'b110});
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) pause = 1'b1;
         tick();
         exp_v = {WIDTH'(seq[i]), 3'b110};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++; $display("FAIL dn_pause[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
      pause = 1'b0;
      tick();
      tests_run++;
      if (obs !== {3'd4, 3'b110}) begin
         tests_failed++; $display("FAIL dn_unpause: got %b expected %b", obs, {3'd4, 3'b110});
      end
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_lo = 3'd0; cfg_if.cfg_hi = 3'd1;
      cfg_if.cfg_mode = 2'b00; cfg_if.cfg_sweeps = 8'd1;
      tests_run++;
      if (cfg_if.cfg_ready !== 1'b0) begin
         tests_failed++; $display("FAIL busy_cfg_ready: got %b expected 0", cfg_if.cfg_ready);
      end
      tick();
      cfg_if.cfg_valid = 1'b0;
      tests_run++;
      if ({obs, err} !== {3'd3, 3'b110, 1'b0}) begin
         tests_failed++; $display("FAIL dn_resume3: got %b expected %b", {obs, err}, {3'd3, 4'b1100});
      end
      tick();
      tests_run++;
      if (obs !== {3'd6, 3'b110}) begin
         tests_failed++; $display("FAIL dn_resume6: got %b expected %b", obs, {3'd6, 3'b110});
      end
      tick();
      tests_run++;
      if (obs !== {3'd5, 3'b110}) begin
         tests_failed++; $display("FAIL dn_resume5: got %b expected %b", obs, {3'd5, 3'b110});
      end
      stop = 1'b1; tick(); stop = 1'b0;
      tests_run++;
      if ({obs, cfg_if.cfg_ready} !== {3'd5, 3'b100, 1'b1}) begin
         tests_failed++; $display("FAIL dn_stop: got %b expected %b", {obs, cfg_if.cfg_ready}, {3'd5, 4'b1001});
      end
      tick();
      tests_run++;
      if (obs !== {3'd5, 3'b100}) begin
         tests_failed++; $display("FAIL dn_frozen: got %b expected %b", obs, {3'd5, 3'b100});
      end
   endtask

   task automatic test_bad_config();
      int bad_lo [3] = '{5, 6, 0};
      int bad_hi [3] = '{5, 2, 7};
      int bad_md [3] = '{0, 2, 3};
      int seq [3] = '{6, 5, 4};
      for (int i = 0; i < 3; i++) begin
         offer(bad_lo[i], bad_hi[i], bad_md[i], 1, 1'b0);
         tests_run++;
         if ({err, busy} !== 2'b10) begin
            tests_failed++; $display("FAIL bad_err[%0d]: got %b expected 10", i, {err, busy});
         end
         tick();
         tests_run++;
         if (err !== 1'b0) begin
            tests_failed++; $display("FAIL bad_err_pulse[%0d]: got %b expected 0", i, err);
         end
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = {WIDTH'(seq[i]), 3'b110};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++; $display("FAIL bad_keep[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic test_reset_midrun();
      offer(2, 6, 2, 0, 1'b1);
      tick(); tick(); tick();
      tests_run++;
      if (obs !== {3'd4, 3'b010}) begin
         tests_failed++; $display("FAIL rst_pre: got %b expected %b", obs, {3'd4, 3'b010});
      end
      rst = 1'b1; pause = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; pause = 1'b0; start = 1'b0;
      tests_run++;
      if ({obs, err, cfg_if.cfg_ready} !== 8'b00000001) begin
         tests_failed++; $display("FAIL rst_mid: got %b expected 00000001", {obs, err, cfg_if.cfg_ready});
      end
      start = 1'b1; tick(); start = 1'b0;
      tick();
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_v = {WIDTH'(i), 3'b010};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++; $display("FAIL rst_dflt[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
      tick();
      tests_run++;
      if (obs !== {3'd6, 3'b110}) begin
         tests_failed++; $display("FAIL rst_dflt_turn: got %b expected %b", obs, {3'd6, 3'b110});
      end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_bounce();
      test_upwrap_sweeps();
      test_bounce_sweeps();
      test_pause_stop();
      test_bad_config();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
